// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared types and constants for the MEM-stage bus bridge:
//                FSM state encoding, access-size encoding, byte-enable
//                patterns and the misalignment check.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_bus_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Access size encoding
    typedef logic [1:0] size_t;
    localparam size_t SZ_BYTE = 2'd0;
    localparam size_t SZ_HALF = 2'd1;
    localparam size_t SZ_WORD = 2'd2;

    // Byte-enable patterns
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // A halfword must sit on an even address, a word on a multiple of four.
    // Bytes can never be misaligned.
    function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/store_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : store_aligner
//  Description : Combinational store lane steering. Produces the byte enables
//                for the addressed lanes and replicates the low store data
//                across all lanes so the slave can pick any of them.
//  Revision    : 1.0  initial release
// ============================================================================
module store_aligner
    import mem_bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_aligned
);

    // Lane selection and data replication by access size
    always_comb begin
        be            = BE_WORD;
        wdata_aligned = wdata;
        case (size)
            SZ_BYTE: begin
                be            = BE_BYTE0 << byte_off;
                wdata_aligned = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be            = byte_off[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_aligned = {2{wdata[15:0]}};
            end
            default: begin
                be            = BE_WORD;
                wdata_aligned = wdata;
            end
        endcase
    end

endmodule : store_aligner
`default_nettype wire

// File: rtl/mem_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_bridge
//  Description : MEM-stage data-access bridge. Turns one pipeline load/store
//                into a req/ack transaction on the system data bus, stalls
//                the pipeline until completion, registers the raw read word
//                for WB, and flags misaligned accesses and bus faults.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] RESET_RD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_half,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rd_raw,
    output logic [1:0]  rd_byte_addr,
    output logic        rd_valid,
    output logic        addr_err,
    output logic        bus_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    // The counter holds the number of REQ cycles already spent; the last
    // permitted cycle is the one in which it reads TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rd_raw_q, rd_raw_d;
    logic [1:0]  rd_byte_addr_q, rd_byte_addr_d;
    logic        rd_valid_q, rd_valid_d;
    logic        addr_err_q, addr_err_d;
    logic        bus_fault_q, bus_fault_d;

    size_t       req_size;
    logic        req_misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    // Byte takes priority over half; anything else is a word access
    always_comb begin
        req_size = req_byte ? SZ_BYTE : (req_half ? SZ_HALF : SZ_WORD);
        req_misaligned = is_misaligned(req_size, req_addr[1:0]);
    end

    store_aligner u_store_aligner (
        .size          (req_size),
        .byte_off      (req_addr[1:0]),
        .wdata         (req_wdata),
        .be            (st_be),
        .wdata_aligned (st_wdata)
    );

    // Next-state logic: accept, bus handshake with timeout, completion pulse
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus_req_d      = bus_req_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_be_d       = bus_be_q;
        bus_wdata_d    = bus_wdata_q;
        rd_raw_d       = rd_raw_q;
        rd_byte_addr_d = rd_byte_addr_q;
        rd_valid_d     = 1'b0;
        addr_err_d     = 1'b0;
        bus_fault_d    = 1'b0;
        stall          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_misaligned) begin
                        addr_err_d = 1'b1;
                    end else begin
                        stall          = 1'b1;
                        state_d        = ST_REQ;
                        cnt_d          = 8'd0;
                        bus_req_d      = 1'b1;
                        bus_we_d       = req_we;
                        bus_addr_d     = {req_addr[31:2], 2'b00};
                        bus_be_d       = req_we ? st_be : BE_WORD;
                        bus_wdata_d    = req_we ? st_wdata : 32'h0000_0000;
                        rd_byte_addr_d = req_addr[1:0];
                    end
                end
            end

            ST_REQ: begin
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                // An ack always wins over a coincident timeout
                if (bus_ack) begin
                    bus_req_d  = 1'b0;
                    rd_valid_d = 1'b1;
                    state_d    = ST_DONE;
                    if (bus_err) begin
                        rd_raw_d    = RESET_RD;
                        bus_fault_d = 1'b1;
                    end else if (!bus_we_q) begin
                        rd_raw_d = bus_rdata;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    bus_req_d   = 1'b0;
                    rd_valid_d  = 1'b1;
                    rd_raw_d    = RESET_RD;
                    bus_fault_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                // req_valid here still belongs to the finished instruction
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops bus_req immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 8'd0;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= 32'h0000_0000;
            bus_be_q       <= 4'b0000;
            bus_wdata_q    <= 32'h0000_0000;
            rd_raw_q       <= RESET_RD;
            rd_byte_addr_q <= 2'b00;
            rd_valid_q     <= 1'b0;
            addr_err_q     <= 1'b0;
            bus_fault_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus_req_q      <= bus_req_d;
            bus_we_q       <= bus_we_d;
            bus_addr_q     <= bus_addr_d;
            bus_be_q       <= bus_be_d;
            bus_wdata_q    <= bus_wdata_d;
            rd_raw_q       <= rd_raw_d;
            rd_byte_addr_q <= rd_byte_addr_d;
            rd_valid_q     <= rd_valid_d;
            addr_err_q     <= addr_err_d;
            bus_fault_q    <= bus_fault_d;
        end
    end

    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = bus_be_q;
    assign bus_wdata    = bus_wdata_q;
    assign rd_raw       = rd_raw_q;
    assign rd_byte_addr = rd_byte_addr_q;
    assign rd_valid     = rd_valid_q;
    assign addr_err     = addr_err_q;
    assign bus_fault    = bus_fault_q;

endmodule : mem_bus_bridge
`default_nettype wire

// File: tb/tb_mem_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_bridge
//  Description : Directed, table-driven bench for mem_bus_bridge with
//                hand-written sequences for timeout, back-to-back accesses
//                and reset during a transaction.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_bridge;

    logic        clk;
    logic        reset_n;
    logic        req_valid, req_we, req_byte, req_half;
    logic [31:0] req_addr, req_wdata;
    logic        stall;
    logic [31:0] rd_raw;
    logic [1:0]  rd_byte_addr;
    logic        rd_valid, addr_err, bus_fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    mem_bus_bridge #(
        .TIMEOUT  (255),
        .RESET_RD (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_byte     (req_byte),
        .req_half     (req_half),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rd_raw       (rd_raw),
        .rd_byte_addr (rd_byte_addr),
        .rd_valid     (rd_valid),
        .addr_err     (addr_err),
        .bus_fault    (bus_fault),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        byt;
        logic        half;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic        err;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] rd;
        logic        fault;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic we, input logic byt, input logic half,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int delay, input logic err, input logic [31:0] rdata,
                                input logic mis, input logic [3:0] be,
                                input logic [31:0] bwdata, input logic [31:0] rd,
                                input logic fault);
        vec_t v;
        v.we = we; v.byt = byt; v.half = half; v.addr = addr; v.wdata = wdata;
        v.delay = delay; v.err = err; v.rdata = rdata; v.mis = mis; v.be = be;
        v.bwdata = bwdata; v.rd = rd; v.fault = fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one pipeline request; starts and ends just after a rising edge
    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] exp_addr;
        exp_addr = {v.addr[31:2], 2'b00};
        req_valid = 1'b1; req_we = v.we; req_byte = v.byt; req_half = v.half;
        req_addr = v.addr; req_wdata = v.wdata;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk($sformatf("v%0d accept_stall", idx), {31'b0, stall}, {31'b0, !v.mis});
        chk($sformatf("v%0d idle_bus_req", idx), {31'b0, bus_req}, 32'd0);
        next_cycle();
        if (v.mis) begin
            req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d addr_err", idx), {31'b0, addr_err}, 32'd1);
            chk($sformatf("v%0d mis_bus_req", idx), {31'b0, bus_req}, 32'd0);
            chk($sformatf("v%0d mis_stall", idx), {31'b0, stall}, 32'd0);
            chk($sformatf("v%0d mis_rd_raw", idx), rd_raw, v.rd);
            next_cycle();
            @(negedge clk);
            chk($sformatf("v%0d addr_err_pulse", idx), {31'b0, addr_err}, 32'd0);
            chk($sformatf("v%0d mis_bus_req2", idx), {31'b0, bus_req}, 32'd0);
            next_cycle();
        end else begin
            for (int c = 1; c <= v.delay; c++) begin
                bus_ack   = (c == v.delay);
                bus_err   = v.err && (c == v.delay);
                bus_rdata = (c == v.delay) ? v.rdata : 32'h0BAD_0BAD;
                @(negedge clk);
                chk($sformatf("v%0d c%0d bus_req", idx, c), {31'b0, bus_req}, 32'd1);
                chk($sformatf("v%0d c%0d stall", idx, c), {31'b0, stall}, 32'd1);
                if (c == 1 || c == v.delay) begin
                    chk($sformatf("v%0d c%0d bus_addr", idx, c), bus_addr, exp_addr);
                    chk($sformatf("v%0d c%0d bus_be", idx, c), {28'b0, bus_be}, {28'b0, v.be});
                    chk($sformatf("v%0d c%0d bus_wdata", idx, c), bus_wdata, v.bwdata);
                    chk($sformatf("v%0d c%0d bus_we", idx, c), {31'b0, bus_we}, {31'b0, v.we});
                end
                next_cycle();
            end
            bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0BAD_0BAD;
            @(negedge clk);
            chk($sformatf("v%0d done_rd_valid", idx), {31'b0, rd_valid}, 32'd1);
            chk($sformatf("v%0d done_stall", idx), {31'b0, stall}, 32'd0);
            chk($sformatf("v%0d done_bus_req", idx), {31'b0, bus_req}, 32'd0);
            chk($sformatf("v%0d done_fault", idx), {31'b0, bus_fault}, {31'b0, v.fault});
            chk($sformatf("v%0d done_rd_raw", idx), rd_raw, v.rd);
            chk($sformatf("v%0d done_byte_addr", idx), {30'b0, rd_byte_addr}, {30'b0, v.addr[1:0]});
            next_cycle();
            req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d post_rd_valid", idx), {31'b0, rd_valid}, 32'd0);
            chk($sformatf("v%0d post_bus_req", idx), {31'b0, bus_req}, 32'd0);
            chk($sformatf("v%0d post_fault", idx), {31'b0, bus_fault}, 32'd0);
            next_cycle();
        end
    endtask

    initial begin
        int          hi;
        bit          done;
        logic [5:0]  pat;
        logic [31:0] memw;

        //              we  byt  half addr          wdata         dly err rdata         mis be       bwdata        rd            flt
        vecs[0]  = mk(1'b1,1'b1,1'b0,32'h0000_1003,32'h1234_56AB, 1, 1'b0,32'h0,        1'b0,4'b1000,32'hABAB_ABAB,32'h0000_0000,1'b0);
        vecs[1]  = mk(1'b0,1'b0,1'b1,32'h0000_2002,32'h0,         3, 1'b0,32'h8001_7FFF,1'b0,4'b1111,32'h0,        32'h8001_7FFF,1'b0);
        vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0000_0006,32'h0,         1, 1'b0,32'h0,        1'b1,4'b0000,32'h0,        32'h8001_7FFF,1'b0);
        vecs[3]  = mk(1'b1,1'b0,1'b1,32'h0000_0005,32'h0,         1, 1'b0,32'h0,        1'b1,4'b0000,32'h0,        32'h8001_7FFF,1'b0);
        vecs[4]  = mk(1'b1,1'b0,1'b1,32'h0000_3006,32'hDEAD_BEEF, 2, 1'b0,32'h0,        1'b0,4'b1100,32'hBEEF_BEEF,32'h8001_7FFF,1'b0);
        vecs[5]  = mk(1'b1,1'b0,1'b1,32'h0000_3000,32'h0000_CAFE, 1, 1'b0,32'h0,        1'b0,4'b0011,32'hCAFE_CAFE,32'h8001_7FFF,1'b0);
        vecs[6]  = mk(1'b1,1'b1,1'b0,32'h0000_4001,32'h0000_0077, 1, 1'b0,32'h0,        1'b0,4'b0010,32'h7777_7777,32'h8001_7FFF,1'b0);
        vecs[7]  = mk(1'b1,1'b1,1'b1,32'h0000_6001,32'h0000_005A, 2, 1'b0,32'h0,        1'b0,4'b0010,32'h5A5A_5A5A,32'h8001_7FFF,1'b0);
        vecs[8]  = mk(1'b0,1'b0,1'b0,32'h0000_0008,32'h0,         1, 1'b1,32'hFFFF_FFFF,1'b0,4'b1111,32'h0,        32'h0000_0000,1'b1);
        vecs[9]  = mk(1'b0,1'b1,1'b0,32'h0000_5003,32'h0,         2, 1'b0,32'h1122_3344,1'b0,4'b1111,32'h0,        32'h1122_3344,1'b0);
        vecs[10] = mk(1'b1,1'b0,1'b0,32'h0000_000C,32'hA5A5_0F0F, 4, 1'b0,32'h0,        1'b0,4'b1111,32'hA5A5_0F0F,32'h1122_3344,1'b0);
        vecs[11] = mk(1'b1,1'b0,1'b0,32'h0000_000D,32'h0,         1, 1'b0,32'h0,        1'b1,4'b0000,32'h0,        32'h1122_3344,1'b0);
        vecs[12] = mk(1'b1,1'b0,1'b0,32'h0000_0014,32'h0000_0001, 1, 1'b1,32'h0,        1'b0,4'b1111,32'h0000_0001,32'h0000_0000,1'b1);
        vecs[13] = mk(1'b0,1'b0,1'b0,32'h0000_0200,32'h0,       255, 1'b0,32'hCAFE_0001,1'b0,4'b1111,32'h0,        32'hCAFE_0001,1'b0);

        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_half = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst bus_req",   {31'b0, bus_req},   32'd0);
        chk("rst bus_we",    {31'b0, bus_we},    32'd0);
        chk("rst stall",     {31'b0, stall},     32'd0);
        chk("rst rd_valid",  {31'b0, rd_valid},  32'd0);
        chk("rst addr_err",  {31'b0, addr_err},  32'd0);
        chk("rst bus_fault", {31'b0, bus_fault}, 32'd0);
        chk("rst bus_be",    {28'b0, bus_be},    32'd0);
        chk("rst bus_addr",  bus_addr,           32'd0);
        chk("rst bus_wdata", bus_wdata,          32'd0);
        chk("rst rd_raw",    rd_raw,             32'd0);
        chk("rst byte_addr", {30'b0, rd_byte_addr}, 32'd0);
        reset_n = 1'b1;
        next_cycle();

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Load with no ack: bus_req for exactly 255 cycles, then fault
        req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_half = 1'b0;
        req_addr = 32'h0000_0100; req_wdata = 32'h0;
        bus_ack = 1'b0; bus_err = 1'b0;
        next_cycle();
        hi = 0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (bus_req) begin
                hi++;
                next_cycle();
            end else begin
                done = 1'b1;
            end
        end
        chk("to completed", {31'b0, done}, 32'd1);
        chk("to req_cycles", hi, 32'd255);
        chk("to fault", {31'b0, bus_fault}, 32'd1);
        chk("to rd_valid", {31'b0, rd_valid}, 32'd1);
        chk("to rd_raw", rd_raw, 32'd0);
        chk("to stall", {31'b0, stall}, 32'd0);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        chk("to idle bus_req", {31'b0, bus_req}, 32'd0);
        chk("to idle rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("to idle fault", {31'b0, bus_fault}, 32'd0);
        next_cycle();

        // Back-to-back sw 0x10 then lw 0x10, ack on first REQ cycle each
        pat = 6'b0; memw = 32'h0;
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 6);
            req_byte = 1'b0; req_half = 1'b0; req_addr = 32'h0000_0010;
            req_we    = (c < 3);
            req_wdata = (c < 3) ? 32'h1357_9BDF : 32'h0;
            bus_ack   = (c == 1) || (c == 4);
            bus_err   = 1'b0;
            bus_rdata = (c == 4) ? memw : 32'h0BAD_0BAD;
            @(negedge clk);
            pat[5 - c] = bus_req;
            if (c == 1 && bus_req && bus_we) memw = bus_wdata;
            if (c == 4) bus_rdata = memw;
            next_cycle();
        end
        req_valid = 1'b0; bus_ack = 1'b0;
        chk("b2b bus_req_pattern", {26'b0, pat}, {26'b0, 6'b010010});
        chk("b2b rd_raw", rd_raw, 32'h1357_9BDF);
        @(negedge clk);
        chk("b2b idle bus_req", {31'b0, bus_req}, 32'd0);
        next_cycle();

        // Reset asserted during REQ: bus_req drops at once, no completion
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0020;
        bus_ack = 1'b0;
        next_cycle();
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk($sformatf("rstmid c%0d bus_req", c), {31'b0, bus_req}, 32'd1);
            next_cycle();
        end
        #2;
        reset_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rstmid async_drop", {31'b0, bus_req}, 32'd0);
        chk("rstmid stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("rstmid p%0d rd_valid", c), {31'b0, rd_valid}, 32'd0);
            chk($sformatf("rstmid p%0d fault", c), {31'b0, bus_fault}, 32'd0);
            chk($sformatf("rstmid p%0d bus_req", c), {31'b0, bus_req}, 32'd0);
        end
        chk("rstmid rd_raw", rd_raw, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_bus_bridge
`default_nettype wire
